// File: rtl/qed_pkg.sv
// ----------------------------------------------------------------------------
// qed_pkg
// Shared definitions for the QED commit tracker slice.
//   qed_trk_state_e : tracker FSM state (IDLE / TRACK / ERROR), 2 bits wide
//   QED_TRK_STATE_W : width of the encoded tracker state
//   QED_MAX_PORTS   : widest commit interface the popcount helper supports
//   qed_popcount    : population count of a QED_MAX_PORTS-bit vector
// ----------------------------------------------------------------------------
package qed_pkg;

   localparam int QED_TRK_STATE_W = 2;
   localparam int QED_MAX_PORTS   = 4;

   typedef enum logic [QED_TRK_STATE_W-1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } qed_trk_state_e;

   // Counts the set bits of a commit-port vector padded to the widest
   // supported interface; three bits are enough for up to four ports.
   function automatic logic [2:0] qed_popcount(input logic [QED_MAX_PORTS-1:0] bits);
      logic [2:0] cnt;
      cnt = '0;
      for (int i = 0; i < QED_MAX_PORTS; i++) begin
         cnt = cnt + {2'b00, bits[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/qed_commit_popcount.sv
// ----------------------------------------------------------------------------
// qed_commit_popcount
// Masked population count across the commit ports: counts the ports where
// both 'valid' and 'qualify' are set.
//   valid   in  NR_COMMIT_PORTS  per-port retire qualifier (already exc-masked)
//   qualify in  NR_COMMIT_PORTS  per-port selector (dup or ~dup)
//   count   out INC_W            number of ports with valid & qualify
// ----------------------------------------------------------------------------
module qed_commit_popcount
   import qed_pkg::*;
#(
   parameter int NR_COMMIT_PORTS = 2,
   parameter int INC_W           = $clog2(NR_COMMIT_PORTS + 1)
) (
   input  logic [NR_COMMIT_PORTS-1:0] valid,
   input  logic [NR_COMMIT_PORTS-1:0] qualify,
   output logic [INC_W-1:0]           count
);

   logic [NR_COMMIT_PORTS-1:0] masked;
   logic [QED_MAX_PORTS-1:0]   padded;

   assign masked = valid & qualify;

   // Narrow interfaces are zero-padded up to the width the shared popcount
   // helper works on, so one function serves every port count.
   always_comb begin
      padded = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         padded[i] = masked[i];
      end
   end

   // The full count never exceeds NR_COMMIT_PORTS, so truncating to INC_W
   // bits loses nothing.
   assign count = INC_W'(qed_popcount(padded));

endmodule

// File: rtl/qed_commit_tracker.sv
// ----------------------------------------------------------------------------
// qed_commit_tracker
// Counts committed original and duplicate instructions over several commit
// ports, flags counter saturation and duplicates running ahead of originals,
// and signals the SQED consistency-check point.
//   clk              in  1      clock
//   rst              in  1      synchronous active-high reset
//   qed_enable_i     in  1      tracking enabled
//   clear_i          in  1      synchronous clear of counters and errors
//   commit_valid_i   in  N      port p retires an instruction this cycle
//   commit_dup_i     in  N      retired instruction on port p is a duplicate
//   commit_exc_i     in  N      retired instruction raised an exception
//   num_orig_o       out CNT_W  committed original count
//   num_dup_o        out CNT_W  committed duplicate count
//   qed_ready_o      out 1      consistency-check point reached
//   err_dup_ahead_o  out 1      sticky: dup count exceeded orig count
//   err_overflow_o   out 1      sticky: a counter saturated
//   state_o          out 2      current FSM state (IDLE=0, TRACK=1, ERROR=2)
//   init_state_o     out 1      counters zero, state IDLE, no errors
// ----------------------------------------------------------------------------
module qed_commit_tracker
   import qed_pkg::*;
#(
   parameter int NR_COMMIT_PORTS = 2,
   parameter int CNT_W           = 16,
   parameter bit CHECK_ON_IDLE   = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       qed_enable_i,
   input  logic                       clear_i,
   input  logic [NR_COMMIT_PORTS-1:0] commit_valid_i,
   input  logic [NR_COMMIT_PORTS-1:0] commit_dup_i,
   input  logic [NR_COMMIT_PORTS-1:0] commit_exc_i,
   output logic [CNT_W-1:0]           num_orig_o,
   output logic [CNT_W-1:0]           num_dup_o,
   output logic                       qed_ready_o,
   output logic                       err_dup_ahead_o,
   output logic                       err_overflow_o,
   output logic [QED_TRK_STATE_W-1:0] state_o,
   output logic                       init_state_o
);

   localparam int INC_W = $clog2(NR_COMMIT_PORTS + 1);

   qed_trk_state_e             state;
   logic [CNT_W-1:0]           cnt_orig;
   logic [CNT_W-1:0]           cnt_dup;
   logic                       err_dup_ahead;
   logic                       err_overflow;

   logic [NR_COMMIT_PORTS-1:0] live;
   logic [INC_W-1:0]           inc_orig;
   logic [INC_W-1:0]           inc_dup;
   logic [CNT_W:0]             sum_orig;
   logic [CNT_W:0]             sum_dup;
   logic                       ovf_orig;
   logic                       ovf_dup;
   logic [CNT_W-1:0]           next_orig;
   logic [CNT_W-1:0]           next_dup;
   logic                       dup_ahead;
   logic                       idle_ok;

   // Excepting instructions never count, whichever stream they belong to.
   assign live = commit_valid_i & ~commit_exc_i;

   qed_commit_popcount #(
      .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
      .INC_W           (INC_W)
   ) u_pop_orig (
      .valid   (live),
      .qualify (~commit_dup_i),
      .count   (inc_orig)
   );

   qed_commit_popcount #(
      .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
      .INC_W           (INC_W)
   ) u_pop_dup (
      .valid   (live),
      .qualify (commit_dup_i),
      .count   (inc_dup)
   );

   // Sums carry one extra bit so a carry-out marks saturation; a saturated
   // counter sticks at all-ones instead of wrapping.
   assign sum_orig  = {1'b0, cnt_orig} + (CNT_W+1)'(inc_orig);
   assign sum_dup   = {1'b0, cnt_dup}  + (CNT_W+1)'(inc_dup);
   assign ovf_orig  = sum_orig[CNT_W];
   assign ovf_dup   = sum_dup[CNT_W];
   assign next_orig = ovf_orig ? {CNT_W{1'b1}} : sum_orig[CNT_W-1:0];
   assign next_dup  = ovf_dup  ? {CNT_W{1'b1}} : sum_dup[CNT_W-1:0];
   assign dup_ahead = next_dup > next_orig;

   // Tracker FSM. Reset and clear share one path since both return the
   // block to its pristine IDLE state; clear also beats enable and commits.
   // IDLE ignores commits even on the enabling cycle, TRACK accumulates and
   // traps into ERROR on saturation or dup-ahead, ERROR freezes everything
   // until cleared.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         state         <= IDLE;
         cnt_orig      <= '0;
         cnt_dup       <= '0;
         err_dup_ahead <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt_orig <= '0;
               cnt_dup  <= '0;
               if (qed_enable_i) begin
                  state <= TRACK;
               end
            end
            TRACK: begin
               if (!qed_enable_i) begin
                  state    <= IDLE;
                  cnt_orig <= '0;
                  cnt_dup  <= '0;
               end else begin
                  cnt_orig <= next_orig;
                  cnt_dup  <= next_dup;
                  if (ovf_orig || ovf_dup) begin
                     err_overflow <= 1'b1;
                  end
                  if (dup_ahead) begin
                     err_dup_ahead <= 1'b1;
                  end
                  if (ovf_orig || ovf_dup || dup_ahead) begin
                     state <= ERROR;
                  end
               end
            end
            ERROR: begin
               state <= ERROR;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // With CHECK_ON_IDLE the check point waits for a commit-free cycle so the
   // harness compares architectural state that is not mid-update.
   assign idle_ok = CHECK_ON_IDLE ? ~|commit_valid_i : 1'b1;

   assign qed_ready_o     = (state == TRACK) && (cnt_orig == cnt_dup) &&
                            (cnt_orig != '0) && idle_ok;
   assign init_state_o    = (state == IDLE) && (cnt_orig == '0) && (cnt_dup == '0) &&
                            !err_dup_ahead && !err_overflow;
   assign num_orig_o      = cnt_orig;
   assign num_dup_o       = cnt_dup;
   assign err_dup_ahead_o = err_dup_ahead;
   assign err_overflow_o  = err_overflow;
   assign state_o         = state;

endmodule

// File: tb/tb_qed_commit_tracker.sv
// ----------------------------------------------------------------------------
// tb_qed_commit_tracker
// Directed bench for qed_commit_tracker with two commit ports, 4-bit counters
// and CHECK_ON_IDLE=1. Each scenario task drives inputs and compares outputs
// against hand-computed values.
// ----------------------------------------------------------------------------
module tb_qed_commit_tracker;

   logic       clk;
   logic       rst;
   logic       qed_enable_i;
   logic       clear_i;
   logic [1:0] commit_valid_i;
   logic [1:0] commit_dup_i;
   logic [1:0] commit_exc_i;
   logic [3:0] num_orig_o;
   logic [3:0] num_dup_o;
   logic       qed_ready_o;
   logic       err_dup_ahead_o;
   logic       err_overflow_o;
   logic [1:0] state_o;
   logic       init_state_o;

   int total;
   int bad;

   qed_commit_tracker #(
      .NR_COMMIT_PORTS (2),
      .CNT_W           (4),
      .CHECK_ON_IDLE   (1'b1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .qed_enable_i    (qed_enable_i),
      .clear_i         (clear_i),
      .commit_valid_i  (commit_valid_i),
      .commit_dup_i    (commit_dup_i),
      .commit_exc_i    (commit_exc_i),
      .num_orig_o      (num_orig_o),
      .num_dup_o       (num_dup_o),
      .qed_ready_o     (qed_ready_o),
      .err_dup_ahead_o (err_dup_ahead_o),
      .err_overflow_o  (err_overflow_o),
      .state_o         (state_o),
      .init_state_o    (init_state_o)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sets every control input at once; settles before any combinational check.
   task automatic applyStimulus(input logic r, input logic en, input logic clr,
                                input logic [1:0] v, input logic [1:0] d, input logic [1:0] e);
      rst            = r;
      qed_enable_i   = en;
      clear_i        = clr;
      commit_valid_i = v;
      commit_dup_i   = d;
      commit_exc_i   = e;
      #1;
   endtask

   // Advances one clock and samples just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      tick();
      total++; if (init_state_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_init: got %b want 1", init_state_o); end
      tick();
      total++; if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
      total++; if (num_orig_o !== 4'd0 || num_dup_o !== 4'd0) begin bad++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", num_orig_o, num_dup_o); end
      total++; if (err_dup_ahead_o !== 1'b0 || err_overflow_o !== 1'b0 || qed_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: got %b%b%b want 000", err_dup_ahead_o, err_overflow_o, qed_ready_o); end
      total++; if (init_state_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_init2: got %b want 1", init_state_o); end
   endtask

   task automatic test_enable();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      total++; if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL enable_pre_state: got %0d want 0", state_o); end
      tick();
      total++; if (state_o !== 2'd1) begin bad++; $display("[TB] FAIL enable_state: got %0d want 1", state_o); end
      total++; if (num_orig_o !== 4'd0 || num_dup_o !== 4'd0) begin bad++; $display("[TB] FAIL enable_counts: got %0d/%0d want 0/0", num_orig_o, num_dup_o); end
      total++; if (init_state_o !== 1'b0) begin bad++; $display("[TB] FAIL enable_init: got %b want 0", init_state_o); end
   endtask

   task automatic test_dual_port();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (num_orig_o !== 4'd2 || num_dup_o !== 4'd0) begin bad++; $display("[TB] FAIL dual_a: got %0d/%0d want 2/0", num_orig_o, num_dup_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 2'b00);
      total++; if (qed_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL dual_b_ready: got %b want 0", qed_ready_o); end
      tick();
      total++; if (num_orig_o !== 4'd2 || num_dup_o !== 4'd2) begin bad++; $display("[TB] FAIL dual_b: got %0d/%0d want 2/2", num_orig_o, num_dup_o); end
      total++; if (qed_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL dual_busy_ready: got %b want 0", qed_ready_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      total++; if (qed_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL dual_idle_ready: got %b want 1", qed_ready_o); end
      tick();
      total++; if (qed_ready_o !== 1'b1 || num_orig_o !== 4'd2 || num_dup_o !== 4'd2) begin bad++; $display("[TB] FAIL dual_hold: got ready=%b %0d/%0d want ready=1 2/2", qed_ready_o, num_orig_o, num_dup_o); end
      // Excepting commits still count as commit activity for the check point.
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b11);
      total++; if (qed_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL dual_exc_ready: got %b want 0", qed_ready_o); end
   endtask

   task automatic test_exceptions();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b01);
      tick();
      total++; if (num_orig_o !== 4'd3 || num_dup_o !== 4'd2) begin bad++; $display("[TB] FAIL exc_orig: got %0d/%0d want 3/2", num_orig_o, num_dup_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b10, 2'b10);
      tick();
      total++; if (num_orig_o !== 4'd4 || num_dup_o !== 4'd2) begin bad++; $display("[TB] FAIL exc_dup: got %0d/%0d want 4/2", num_orig_o, num_dup_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      total++; if (qed_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL exc_ready: got %b want 0", qed_ready_o); end
   endtask

   task automatic test_dup_ahead();
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (state_o !== 2'd0 || num_orig_o !== 4'd0 || init_state_o !== 1'b1) begin bad++; $display("[TB] FAIL clear_track: got st=%0d orig=%0d init=%b want 0/0/1", state_o, num_orig_o, init_state_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      total++; if (qed_ready_o !== 1'b1 || num_orig_o !== 4'd1 || num_dup_o !== 4'd1) begin bad++; $display("[TB] FAIL ahead_setup: got ready=%b %0d/%0d want ready=1 1/1", qed_ready_o, num_orig_o, num_dup_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 2'b00);
      tick();
      total++; if (err_dup_ahead_o !== 1'b1 || err_overflow_o !== 1'b0) begin bad++; $display("[TB] FAIL ahead_err: got ahead=%b ovf=%b want 1/0", err_dup_ahead_o, err_overflow_o); end
      total++; if (state_o !== 2'd2) begin bad++; $display("[TB] FAIL ahead_state: got %0d want 2", state_o); end
      total++; if (num_orig_o !== 4'd1 || num_dup_o !== 4'd3) begin bad++; $display("[TB] FAIL ahead_counts: got %0d/%0d want 1/3", num_orig_o, num_dup_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (num_orig_o !== 4'd1 || num_dup_o !== 4'd3 || state_o !== 2'd2 || err_dup_ahead_o !== 1'b1) begin bad++; $display("[TB] FAIL ahead_frozen: got %0d/%0d st=%0d err=%b want 1/3 st=2 err=1", num_orig_o, num_dup_o, state_o, err_dup_ahead_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      total++; if (qed_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL ahead_ready: got %b want 0", qed_ready_o); end
   endtask

   task automatic test_overflow();
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00);
      tick();
      total++; if (err_dup_ahead_o !== 1'b0 || state_o !== 2'd0 || num_dup_o !== 4'd0) begin bad++; $display("[TB] FAIL clear_error: got err=%b st=%0d dup=%0d want 0/0/0", err_dup_ahead_o, state_o, num_dup_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      tick();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
         tick();
      end
      total++; if (num_orig_o !== 4'd14 || state_o !== 2'd1 || err_overflow_o !== 1'b0) begin bad++; $display("[TB] FAIL ovf_setup: got orig=%0d st=%0d ovf=%b want 14/1/0", num_orig_o, state_o, err_overflow_o); end
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (num_orig_o !== 4'd15) begin bad++; $display("[TB] FAIL ovf_sat: got %0d want 15", num_orig_o); end
      total++; if (err_overflow_o !== 1'b1 || err_dup_ahead_o !== 1'b0) begin bad++; $display("[TB] FAIL ovf_err: got ovf=%b ahead=%b want 1/0", err_overflow_o, err_dup_ahead_o); end
      total++; if (state_o !== 2'd2) begin bad++; $display("[TB] FAIL ovf_state: got %0d want 2", state_o); end
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (num_orig_o !== 4'd0 || num_dup_o !== 4'd0) begin bad++; $display("[TB] FAIL ovf_clear_counts: got %0d/%0d want 0/0", num_orig_o, num_dup_o); end
      total++; if (err_overflow_o !== 1'b0 || state_o !== 2'd0 || init_state_o !== 1'b1) begin bad++; $display("[TB] FAIL ovf_clear_state: got ovf=%b st=%0d init=%b want 0/0/1", err_overflow_o, state_o, init_state_o); end
   endtask

   task automatic test_disable();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 2'b00);
      tick();
      total++; if (num_orig_o !== 4'd3 || num_dup_o !== 4'd1) begin bad++; $display("[TB] FAIL dis_setup: got %0d/%0d want 3/1", num_orig_o, num_dup_o); end
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (state_o !== 2'd0) begin bad++; $display("[TB] FAIL dis_state: got %0d want 0", state_o); end
      total++; if (num_orig_o !== 4'd0 || num_dup_o !== 4'd0 || init_state_o !== 1'b1) begin bad++; $display("[TB] FAIL dis_counts: got %0d/%0d init=%b want 0/0 init=1", num_orig_o, num_dup_o, init_state_o); end
   endtask

   task automatic test_reset_override();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (num_orig_o !== 4'd2) begin bad++; $display("[TB] FAIL rst_ovr_setup: got %0d want 2", num_orig_o); end
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
      tick();
      total++; if (state_o !== 2'd0 || num_orig_o !== 4'd0 || init_state_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_ovr: got st=%0d orig=%0d init=%b want 0/0/1", state_o, num_orig_o, init_state_o); end
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
   endtask

   // Scenario sequence; each task starts from where the previous one left off.
   initial begin
      total = 0;
      bad   = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      test_reset();
      test_enable();
      test_dual_port();
      test_exceptions();
      test_dup_ahead();
      test_overflow();
      test_disable();
      test_reset_override();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qed_commit_tracker.md
Name: qed_commit_tracker

Overview:
Parametrised successor to the fixed single-port QED orig/dup counters. Tracks committed original and duplicate instructions across NR_COMMIT_PORTS commit ports, with saturation/overflow detection and a duplicate-ahead error. Asserts the SQED consistency-check point when orig and dup counts are equal and non-zero. Exposes an all-zero initial-state flag that formal harnesses constrain at cycle 0. Sits beside the QED module in the core top and taps the commit stage.

Parameters:
NR_COMMIT_PORTS, 2, number of commit ports observed per cycle (1..4)
CNT_W, 16, width of orig/dup counters (4..32)
CHECK_ON_IDLE, 1, 1: qed_ready_o also requires no commit in the current cycle; 0: ignore current-cycle commits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
qed_enable_i  in  1  tracking enabled
clear_i  in  1  synchronous clear of counters and errors
commit_valid_i  in  NR_COMMIT_PORTS  commit port p retires an instruction this cycle
commit_dup_i  in  NR_COMMIT_PORTS  retired instruction on port p is a duplicate
commit_exc_i  in  NR_COMMIT_PORTS  retired instruction on port p raised an exception; not counted
num_orig_o  out  CNT_W  committed original count
num_dup_o  out  CNT_W  committed duplicate count
qed_ready_o  out  1  consistency-check point reached
err_dup_ahead_o  out  1  sticky: dup count exceeded orig count
err_overflow_o  out  1  sticky: a counter saturated
state_o  out  2  current FSM state
init_state_o  out  1  counters zero, state IDLE, no errors

Behaviour:
- Reset (rst=1 at clk edge): counters 0, state IDLE, errors 0, qed_ready_o 0, init_state_o 1. Reset overrides every other input.
- Per-cycle increments:
  - inc_orig = popcount(valid & ~exc & ~dup); inc_dup = popcount(valid & ~exc & dup).
  - Both are computed on $clog2(NR_COMMIT_PORTS+1) bits and zero-extended to CNT_W+1 bits for the add.
- FSM states, encoded in state_o: IDLE=0, TRACK=1, ERROR=2.
  - IDLE: counters held at 0; commits ignored. qed_enable_i=1 -> TRACK, and commits in the same cycle are ignored. First counting occurs the cycle after entering TRACK.
  - TRACK: counters update every cycle.
    - Overflow: if orig+inc_orig or dup+inc_dup exceeds 2^CNT_W-1, that counter saturates at all-ones, err_overflow_o is set, and the FSM goes to ERROR.
    - Dup-ahead: else if next dup > next orig, set err_dup_ahead_o and go to ERROR. Counters take their next values.
    - If both overflow and dup-ahead occur in the same cycle, set both errors.
    - qed_enable_i=0 -> IDLE with counters cleared next cycle.
  - ERROR: counters frozen; errors sticky. Exit only via clear_i or rst; both go to IDLE with counters and errors cleared.
- clear_i in any state: next cycle, counters 0, errors 0, state IDLE. clear_i beats commits and qed_enable_i in the same cycle.
- qed_ready_o is combinational from registers (zero latency after the counter update):
  - Condition: state==TRACK && num_orig==num_dup && num_orig!=0.
  - When CHECK_ON_IDLE=1, additionally requires ~|commit_valid_i.
- init_state_o = (state==IDLE) && num_orig==0 && num_dup==0 && no errors.
- Counters never wrap.

Decomposition:
- Shared package qed_pkg:
  - qed_trk_state_e enum (IDLE/TRACK/ERROR, 2 bits)
  - constant QED_TRK_STATE_W=2
  - function qed_popcount
- One natural sub-module: qed_commit_popcount (NR_COMMIT_PORTS-wide masked popcount, instantiated twice: orig and dup).
- Formal harnesses assume init_state_o==1 at the first clock instead of probing internal hierarchy.

Test Plan:
- Reset and enable:
  - Stimulus: rst 2 cycles, then qed_enable_i=1 with commit_valid_i=2'b11 in the same cycle.
  - Required: state_o 0 -> 1; counts stay 0 that cycle; init_state_o=1 during reset.
- Dual-port counting (N=2, CNT_W=4):
  - Stimulus: cycle A valid=11, dup=00; cycle B valid=11, dup=11; then idle.
  - Required: orig=2, dup=2, qed_ready_o=1 on the idle cycle; with CHECK_ON_IDLE=1, qed_ready_o=0 during cycle B.
- Exceptions:
  - Stimulus: valid=11, exc=01, dup=00.
  - Required: orig +1 only.
- Dup-ahead:
  - Stimulus: from orig=1/dup=1, commit valid=11, dup=11.
  - Required: err_dup_ahead_o=1, state_o=2, counters frozen at 1/3.
- Overflow (CNT_W=4):
  - Stimulus: drive orig to 14, then valid=11, dup=00.
  - Required: orig=15, err_overflow_o=1, state ERROR.
  - Then: clear_i with valid=11 in the same cycle -> counters 0, errors 0, state IDLE.
- Disable mid-run:
  - Stimulus: orig=3/dup=1, drop qed_enable_i.
  - Required: next cycle state IDLE, counters 0, init_state_o=1.
